// File: rtl/multiword_adder_seq.sv
// Wide unsigned adder that time-multiplexes one ADDER_WIDTH-bit ripple-carry adder
// over NUM_WORDS words, LSW first, with valid/ready handshakes on both sides.
module multiword_adder_seq #(
  parameter int ADDER_WIDTH = 16,
  parameter int NUM_WORDS   = 4
) (
  input  logic                             iClk,
  input  logic                             iRst,
  input  logic                             iValid,
  output logic                             oReady,
  input  logic [ADDER_WIDTH*NUM_WORDS-1:0] iA,
  input  logic [ADDER_WIDTH*NUM_WORDS-1:0] iB,
  input  logic                             iCarry,
  output logic                             oValid,
  input  logic                             iReady,
  output logic [ADDER_WIDTH*NUM_WORDS-1:0] oSum,
  output logic                             oCarry
);

  localparam int TOTAL = ADDER_WIDTH * NUM_WORDS;
  localparam int CNT_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} stateT;

  stateT                  state;
  stateT                  stateNext;
  logic [CNT_W-1:0]       wordIdx;
  logic                   carryReg;
  logic [TOTAL-1:0]       opA;
  logic [TOTAL-1:0]       opB;
  logic [ADDER_WIDTH-1:0] wordA;
  logic [ADDER_WIDTH-1:0] wordB;
  logic [ADDER_WIDTH-1:0] wordSum;
  logic                   wordCarry;
  logic                   lastWord;

  assign wordA    = opA[wordIdx*ADDER_WIDTH +: ADDER_WIDTH];
  assign wordB    = opB[wordIdx*ADDER_WIDTH +: ADDER_WIDTH];
  assign lastWord = (wordIdx == CNT_W'(NUM_WORDS - 1));

  // Shared word adder; carryReg holds iCarry for word 0, then the inter-word carry.
  always_comb begin : rippleAdder
    logic c;
    c       = carryReg;
    wordSum = '0;
    for (int i = 0; i < ADDER_WIDTH; i++) begin
      wordSum[i] = wordA[i] ^ wordB[i] ^ c;
      c          = (wordA[i] & wordB[i]) | (c & (wordA[i] ^ wordB[i]));
    end
    wordCarry = c;
  end

  always_comb begin
    stateNext = state;
    oReady    = 1'b0;
    oValid    = 1'b0;
    case (state)
      IDLE: begin
        oReady = !iRst;
        if (iValid) stateNext = RUN;
      end
      RUN: begin
        if (lastWord) stateNext = DONE;
      end
      DONE: begin
        oValid = 1'b1;
        if (iReady) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state    <= IDLE;
      wordIdx  <= '0;
      carryReg <= 1'b0;
      opA      <= '0;
      opB      <= '0;
      oSum     <= '0;
      oCarry   <= 1'b0;
    end else begin
      state <= stateNext;
      case (state)
        IDLE: begin
          if (iValid) begin
            opA      <= iA;
            opB      <= iB;
            carryReg <= iCarry;
            wordIdx  <= '0;
          end
        end
        RUN: begin
          oSum[wordIdx*ADDER_WIDTH +: ADDER_WIDTH] <= wordSum;
          carryReg <= wordCarry;
          // Counter wraps to 0 on the last word so it never exceeds NUM_WORDS-1.
          if (lastWord) begin
            oCarry  <= wordCarry;
            wordIdx <= '0;
          end else begin
            wordIdx <= wordIdx + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
